// File: rtl/glb_port_arbiter.sv
// glb_port_arbiter: shares the single GLB read port and the single GLB write
// port between NUM_REQ requesters using round-robin arbitration with bounded
// burst locking. GLB strobes, addresses and data come combinationally from the
// granted requester. Read data, which has one cycle of latency, is tagged back
// to the port that issued the read.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rd_req/rd_lock/rd_be/rd_addr   per-port read request, lock, byte enable, address
//   rd_gnt                   one-hot read grant, in the same cycle as the request
//   rd_rvalid/rd_data        one-hot return tag, and the shared read data
//   wr_req/wr_lock/wr_be/wr_addr/wr_data  per-port write request fields
//   wr_gnt                   one-hot write grant, in the same cycle as the request
//   glb_re/glb_r_addr/glb_r_data   GLB read port
//   glb_we/glb_w_addr/glb_w_data   GLB write port

// A single arbiter with a priority pointer, a last owner and a lock counter.
module glb_port_arb_core #(
  parameter int NUM_REQ  = 2,
  parameter int LOCK_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ-1:0]   i_lock,
  input  logic [4*NUM_REQ-1:0] i_be,
  output logic [NUM_REQ-1:0]   o_gnt
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LW = $clog2(LOCK_MAX + 1);

  logic [NUM_REQ-1:0] w_act;
  logic [IW-1:0]      r_ptr, r_own, w_sel;
  logic [LW-1:0]      r_lcnt;
  logic               w_cont, w_any;

  always_comb begin
    int idx;
    idx = 0;
    // A request with all byte enables low counts as no request.
    for (int i = 0; i < NUM_REQ; i++) w_act[i] = i_req[i] & (|i_be[4*i +: 4]);
    // The owner keeps the port while it stays locked. Once it has LOCK_MAX
    // grants it must win a normal round-robin scan instead.
    w_cont = w_act[r_own] & i_lock[r_own] & (r_lcnt < LW'(LOCK_MAX));
    w_sel  = '0;
    w_any  = 1'b0;
    if (w_cont) begin
      w_sel = r_own;
      w_any = 1'b1;
    end else begin
      // The scan runs downward, so the port closest to ptr is written last and wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = (int'(r_ptr) + k) % NUM_REQ;
        if (w_act[idx]) begin
          w_sel = IW'(idx);
          w_any = 1'b1;
        end
      end
    end
    if (rst) w_any = 1'b0;
    o_gnt = '0;
    if (w_any) o_gnt[w_sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr  <= '0;
      r_own  <= '0;
      r_lcnt <= '0;
    end else if (w_any) begin
      r_own  <= w_sel;
      r_lcnt <= w_cont ? r_lcnt + LW'(1) : LW'(1);
      r_ptr  <= (w_sel == IW'(NUM_REQ - 1)) ? '0 : w_sel + IW'(1);
    end else begin
      r_lcnt <= '0;
    end
  end
endmodule

module glb_port_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int DATA_SIZE = 32,
  parameter int ADDR_BITS = 32,
  parameter int LOCK_MAX  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             rd_req,
  input  logic [NUM_REQ-1:0]             rd_lock,
  input  logic [4*NUM_REQ-1:0]           rd_be,
  input  logic [ADDR_BITS*NUM_REQ-1:0]   rd_addr,
  output logic [NUM_REQ-1:0]             rd_gnt,
  output logic [NUM_REQ-1:0]             rd_rvalid,
  output logic [DATA_SIZE-1:0]           rd_data,
  input  logic [NUM_REQ-1:0]             wr_req,
  input  logic [NUM_REQ-1:0]             wr_lock,
  input  logic [4*NUM_REQ-1:0]           wr_be,
  input  logic [ADDR_BITS*NUM_REQ-1:0]   wr_addr,
  input  logic [DATA_SIZE*NUM_REQ-1:0]   wr_data,
  output logic [NUM_REQ-1:0]             wr_gnt,
  output logic [3:0]                     glb_re,
  output logic [ADDR_BITS-1:0]           glb_r_addr,
  input  logic [DATA_SIZE-1:0]           glb_r_data,
  output logic [3:0]                     glb_we,
  output logic [ADDR_BITS-1:0]           glb_w_addr,
  output logic [DATA_SIZE-1:0]           glb_w_data
);
  logic [NUM_REQ-1:0] r_rtag;

  glb_port_arb_core #(.NUM_REQ(NUM_REQ), .LOCK_MAX(LOCK_MAX)) u_rd_arb (
    .clk(clk), .rst(rst), .i_req(rd_req), .i_lock(rd_lock), .i_be(rd_be), .o_gnt(rd_gnt)
  );

  glb_port_arb_core #(.NUM_REQ(NUM_REQ), .LOCK_MAX(LOCK_MAX)) u_wr_arb (
    .clk(clk), .rst(rst), .i_req(wr_req), .i_lock(wr_lock), .i_be(wr_be), .o_gnt(wr_gnt)
  );

  // The grants are one-hot, so an AND-OR mux selects the granted port. With no
  // grant, everything sent to GLB is zero.
  always_comb begin
    glb_re     = '0;
    glb_r_addr = '0;
    glb_we     = '0;
    glb_w_addr = '0;
    glb_w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rd_gnt[i]) begin
        glb_re     = rd_be[4*i +: 4];
        glb_r_addr = rd_addr[ADDR_BITS*i +: ADDR_BITS];
      end
      if (wr_gnt[i]) begin
        glb_we     = wr_be[4*i +: 4];
        glb_w_addr = wr_addr[ADDR_BITS*i +: ADDR_BITS];
        glb_w_data = wr_data[DATA_SIZE*i +: DATA_SIZE];
      end
    end
  end

  // The return tag follows the GLB read latency. Reset clears it, so a read in
  // flight when reset arrives is never delivered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rtag <= '0;
    else     r_rtag <= rd_gnt;
  end

  assign rd_rvalid = r_rtag;
  assign rd_data   = (|r_rtag) ? glb_r_data : '0;
endmodule

// File: tb/tb_glb_port_arbiter.sv
// Directed bench for glb_port_arbiter. It uses two ports and a small
// write-first GLB memory model.
module tb_glb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rd_req = '0, rd_lock = '0, rd_gnt, rd_rvalid;
  logic [7:0]  rd_be = '0;
  logic [63:0] rd_addr = '0;
  logic [31:0] rd_data;
  logic [1:0]  wr_req = '0, wr_lock = '0, wr_gnt;
  logic [7:0]  wr_be = '0;
  logic [63:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [3:0]  glb_re, glb_we;
  logic [31:0] glb_r_addr, glb_w_addr, glb_w_data;
  logic [31:0] glb_r_data = '0;
  logic [31:0] mem [256];

  int n_chk = 0;
  int n_fail = 0;

  glb_port_arbiter #(.NUM_REQ(2), .DATA_SIZE(32), .ADDR_BITS(32), .LOCK_MAX(16)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_lock(rd_lock), .rd_be(rd_be), .rd_addr(rd_addr),
    .rd_gnt(rd_gnt), .rd_rvalid(rd_rvalid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_lock(wr_lock), .wr_be(wr_be), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_gnt(wr_gnt),
    .glb_re(glb_re), .glb_r_addr(glb_r_addr), .glb_r_data(glb_r_data),
    .glb_we(glb_we), .glb_w_addr(glb_w_addr), .glb_w_data(glb_w_data)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;

  // GLB model. On a same-address collision the write data goes straight to the read port.
  always @(posedge clk) begin
    if (|glb_re)
      glb_r_data <= (|glb_we && glb_w_addr == glb_r_addr) ? glb_w_data : mem[glb_r_addr[9:2]];
    if (|glb_we) mem[glb_w_addr[9:2]] <= glb_w_data;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // Reset with a request present: grants and strobes must be held low.
    tick();
    rd_req = 2'b01; rd_be = 8'h0F; rd_addr = 64'h10;
    wr_req = 2'b01; wr_be = 8'h0F;
    #1;
    chk("rst_rd_gnt", 32'(rd_gnt), 32'h0);
    chk("rst_wr_gnt", 32'(wr_gnt), 32'h0);
    chk("rst_glb_re", 32'(glb_re), 32'h0);
    chk("rst_glb_we", 32'(glb_we), 32'h0);
    chk("rst_rvalid", 32'(rd_rvalid), 32'h0);
    wr_req = '0; wr_be = '0;
    tick();
    rst = 1'b0;
    #1;

    // A single read from port 0.
    chk("t1_gnt", 32'(rd_gnt), 32'h1);
    chk("t1_raddr", glb_r_addr, 32'h10);
    chk("t1_re", 32'(glb_re), 32'hF);
    tick();
    rd_req = '0;
    #1;
    chk("t1_rvalid", 32'(rd_rvalid), 32'h1);
    chk("t1_rdata", rd_data, 32'h1000_0004);
    tick();
    chk("t1_rvalid_off", 32'(rd_rvalid), 32'h0);

    // Two ports reading with no lock: grants alternate.
    do_reset();
    rd_req = 2'b11; rd_be = 8'hFF; rd_addr = {32'h30, 32'h20};
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_gnt", 32'(rd_gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      chk("t2_rvalid", 32'(rd_rvalid), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("t2_rdata", rd_data, (k % 2 == 0) ? 32'h1000_0008 : 32'h1000_000C);
    end
    rd_req = '0;

    // Port 1 holds a write lock while port 0 also writes: after one grant to
    // port 0, port 1 gets 16 grants, then port 0 gets one.
    do_reset();
    wr_req = 2'b11; wr_lock = 2'b10; wr_be = 8'hFF;
    wr_addr = {32'h104, 32'h100}; wr_data = {32'h2222_0000, 32'h1111_0000};
    for (int k = 0; k < 19; k++) begin
      #1;
      chk("t3_wgnt", 32'(wr_gnt), (k == 0 || k == 17) ? 32'h1 : 32'h2);
      if (k == 0) chk("t3_wdata0", glb_w_data, 32'h1111_0000);
      if (k == 1) chk("t3_waddr1", glb_w_addr, 32'h104);
      tick();
    end
    wr_req = '0; wr_lock = '0; wr_be = '0;

    // A read and a write to the same address in one cycle: the read returns the new data.
    rd_req = 2'b01; rd_be = 8'h0F; rd_addr = 64'h40;
    wr_req = 2'b01; wr_be = 8'h0F; wr_addr = 64'h40; wr_data = 64'hDEADBEEF;
    #1;
    chk("t4_rgnt", 32'(rd_gnt), 32'h1);
    chk("t4_wgnt", 32'(wr_gnt), 32'h1);
    chk("t4_wdata", glb_w_data, 32'hDEADBEEF);
    tick();
    rd_req = '0; wr_req = '0; wr_be = '0;
    #1;
    chk("t4_rdata", rd_data, 32'hDEADBEEF);

    // A port requesting with be=0 is ignored.
    do_reset();
    rd_req = 2'b11; rd_be = 8'hF0; rd_addr = {32'h50, 32'h60};
    #1;
    chk("t5_gnt", 32'(rd_gnt), 32'h2);
    chk("t5_re", 32'(glb_re), 32'hF);
    chk("t5_raddr", glb_r_addr, 32'h50);
    tick();
    rd_req = '0;

    // Reset arrives while a read is in flight: rvalid is dropped and the pointer restarts at port 0.
    do_reset();
    rd_req = 2'b01; rd_be = 8'h0F; rd_addr = 64'h10;
    #1;
    chk("t6_gnt", 32'(rd_gnt), 32'h1);
    tick();
    rd_req = '0;
    rst = 1'b1;
    #1;
    chk("t6_rvalid_rst", 32'(rd_rvalid), 32'h0);
    tick();
    chk("t6_rvalid_hold", 32'(rd_rvalid), 32'h0);
    rst = 1'b0;
    rd_req = 2'b11; rd_be = 8'hFF; rd_addr = {32'h30, 32'h20};
    #1;
    chk("t6_gnt_after", 32'(rd_gnt), 32'h1);
    tick();
    rd_req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/glb_port_arbiter.md
# glb_port_arbiter

Round-robin arbiter that shares the single GLB read port and single GLB write port between NUM_REQ requesters: port 0 is the pass controller, higher ports are loaders/DMA or a second controller. It sits between the requesters and GLB, drives GLB `re`/`r_addr`/`we`/`w_addr`/`din` combinationally from the granted requester, and steers the 1-cycle-latency read data back to the port that issued it. Bounded burst locking lets a requester hold a port for contiguous accesses without starving the others.

## Interface

- NUM_REQ, 2: number of requesters (2..4).
- DATA_SIZE, 32: GLB data width.
- ADDR_BITS, 32: byte address width.
- LOCK_MAX, 16: maximum consecutive locked grants before a forced hand-over.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_req  in  NUM_REQ  per-port read request.
- rd_lock  in  NUM_REQ  per-port burst lock, keeps read grant.
- rd_be  in  4*NUM_REQ  per-port byte read enable, port i at [4i+3:4i].
- rd_addr  in  ADDR_BITS*NUM_REQ  per-port byte address.
- rd_gnt  out  NUM_REQ  one-hot read grant, same cycle as request.
- rd_rvalid  out  NUM_REQ  one-hot, read data valid for that port.
- rd_data  out  DATA_SIZE  returned read data (shared by all ports).
- wr_req, wr_lock  in  NUM_REQ  per-port write request / burst lock.
- wr_be  in  4*NUM_REQ  per-port byte write enable.
- wr_addr  in  ADDR_BITS*NUM_REQ  per-port byte address.
- wr_data  in  DATA_SIZE*NUM_REQ  per-port write data.
- wr_gnt  out  NUM_REQ  one-hot write grant, same cycle.
- glb_re  out  4  to GLB read enable.
- glb_r_addr  out  ADDR_BITS  to GLB read address.
- glb_r_data  in  DATA_SIZE  from GLB, valid 1 cycle after glb_re.
- glb_we  out  4  to GLB write enable.
- glb_w_addr  out  ADDR_BITS  to GLB write address.
- glb_w_data  out  DATA_SIZE  to GLB write data.

## Operation

- Read and write arbiters are independent identical instances; each has a priority pointer `ptr`, a last-owner register `own`, and a lock counter `lcnt` (clog2(LOCK_MAX+1) bits).
- Grant (combinational): if `own` requesting, its lock bit high and `lcnt` < LOCK_MAX → grant `own`. Else grant first requesting port scanning from `ptr` upward, wrapping modulo NUM_REQ. No request → no grant.
- On a grant to port g: `own`←g; if the grant was a lock continuation `lcnt`←`lcnt`+1, else `lcnt`←1; `ptr`←(g+1) mod NUM_REQ. No grant: `ptr`,`own` held, `lcnt`←0.
- Forced hand-over: at `lcnt`==LOCK_MAX the owner loses lock priority for that cycle; it is still granted if it is the only requester (lcnt then restarts at 1).
- Requests with be==0 are treated as not requesting.
- GLB drive: glb_re/glb_r_addr = granted port's be/addr, else 0; same for write path with data. No grant → glb_re=0, glb_we=0, addresses/data 0.
- Return path: register `rtag` (one-hot, port granted) on each read grant; rd_rvalid=`rtag` next cycle, rd_data=glb_r_data.
- Same-cycle read and write to same address: GLB is write-first; arbiter passes both, read returns new data.

## Timing

- Grant-to-GLB: 0 cycles (combinational). Read data: exactly 1 cycle after grant; back-to-back reads sustain 1 per cycle.
- Requester holds req/addr/be stable until it sees gnt; gnt is an accept in that cycle.
- Reset (async): ptr=0, own=0, lcnt=0, rtag=0; rd_rvalid=0, rd_data=glb_r_data only gated by rtag. While rst high all grants, glb_re and glb_we forced to 0.
- Reset mid-read: outstanding rvalid is dropped, not delivered.

## Test plan

- Reset, then port 0 read addr 0x10 be 4'hF alone → rd_gnt=01, glb_r_addr=0x10; next cycle rd_rvalid=01, rd_data=GLB word.
- Ports 0 and 1 read continuously, no lock → grants alternate 01,10,01,10; rvalid follows 1 cycle later.
- Port 1 write with wr_lock held, port 0 writing → port 1 gets exactly 16 consecutive grants, then port 0 granted once.
- Read and write same address 0x40 in one cycle, data 0xDEADBEEF → read returns 0xDEADBEEF.
- Port 0 requests with be=0 while port 1 requests → only port 1 granted.
- Assert rst on the cycle after a read grant → rd_rvalid stays 0, next grant starts at port 0.
